alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Issue-side wrapper for the single-cycle ALU datapath.
- Accepts one op per cycle from the ALU reservation station over a valid/ready handshake and registers the operands.
- Evaluates the op through an internal alu_simple instance and buffers tagged results in a small FIFO.
- Drives the results onto the common data bus (CDB) under a request/grant arbiter, and supports pipeline flush on misprediction.

Parameters:
- DEPTH, 2, result FIFO entries; power of two, ≥2.
- ROB_W, 7, ROB tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- issue_valid  in  1  reservation station presents an op.
- issue_ready  out  1  stage can accept an op this cycle.
- issue_op  in  5  ALU opcode, alu_simple encoding.
- issue_op1  in  32  operand 1.
- issue_op2  in  32  operand 2.
- issue_robid  in  ROB_W  destination ROB tag.
- flush  in  1  discard all in-flight work.
- cdb_req  out  1  head result waiting for CDB.
- cdb_grant  in  1  arbiter grants CDB to this unit.
- cdb_robid  out  ROB_W  head tag.
- cdb_result  out  32  head result.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset state:
  - a_valid=0, FIFO count=0, head/tail pointers=0, FIFO storage=0.
  - cdb_req=0, cdb_robid=0, cdb_result=0.
  - issue_ready=1 in the first cycle after reset release.
- Stage A (operand latch):
  - Holds a_valid, a_op, a_op1, a_op2, a_robid.
  - space = (count < DEPTH), registered count only; no pop lookahead.
  - a_adv = a_valid & space.
  - issue_ready = ~a_valid | a_adv (combinational).
  - Accept = issue_valid & issue_ready. The accepted op is loaded into Stage A the next cycle.
  - If a_adv and no accept, a_valid clears.
  - If Stage A is blocked (a_valid & ~space), it holds all of its fields unchanged.
- ALU evaluation:
  - alu_simple is driven from the Stage A registers.
  - When a_adv is set, {a_robid, sc_result} is written at the tail and tail increments (mod DEPTH).
- FIFO / CDB:
  - cdb_req = (count != 0). cdb_robid and cdb_result reflect the head entry.
  - Pop = cdb_req & cdb_grant: head increments (mod DEPTH).
  - cdb_grant with cdb_req=0 is ignored.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when count==DEPTH cannot occur by construction; assertion required.
- Latency and throughput:
  - Op accepted in cycle N: Stage A valid in N+1, cdb_req visible in N+2 at the earliest.
  - Sustained 1 op/cycle when granted every cycle.
  - With no grant, the FIFO fills to DEPTH, then Stage A holds, then issue_ready drops.
- Flush:
  - Next cycle: a_valid=0, count=0, pointers=0. Storage contents are don't-care.
  - An op accepted in the flush cycle is discarded.
  - A pop in the flush cycle still counts as delivered to the CDB.
  - Flush overrides push.
  - Reset overrides flush.
- Opcode handling: all 5-bit opcodes are passed through unmodified, including the op[4] priority extensions. The ALU is purely combinational, so a result is always produced one cycle after latching.

Optional Feature:
- Macro: ALU_EXEC_STATS_EN.
- When defined:
  - Adds outputs stat_issued[31:0] (+1 per accepted op) and stat_flushed[31:0] (+ number of ops discarded by a flush: a_valid + count + same-cycle accept, minus the same-cycle pop).
  - Adds stat_stall[31:0] (+1 per cycle with issue_valid & ~issue_ready).
  - All counters reset to 0 and wrap at 2^32.
- When undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Single op, grant held at 1: reset, then issue op=5'b00000, op1=7, op2=5, robid=3 in cycle 1 -> cdb_req=1 in cycle 3 with cdb_robid=3, cdb_result=12; cdb_req=0 in cycle 4.
- Back-to-back, no grant: issue SUB 10-3 (robid 1), SLL 1<<4 (robid 2), XOR 0xF0^0xFF (robid 3), OR 1|2 (robid 4) with cdb_grant=0 -> FIFO holds 7 then 16, Stage A holds robid 3, issue_ready=0 while robid 4 is presented. Then grant every cycle -> CDB order robid 1,2,3,4 with results 7,16,0x0F,3.
- Priority extension op=5'b10000, op1=0x0000_0F00, op2=0x0000_0100 -> cdb_result=0x0000_0009. Op=5'b10001 with the same operands -> cdb_result=0x0000_0D00.
- Flush with FIFO=2 and Stage A valid, plus a same-cycle issue -> next cycle cdb_req=0, issue_ready=1, and no stale tag ever appears on the CDB. A new op (robid 9, ADD 1+1) then returns 2 at N+2.
- Reset mid-stream (rst_n=0 for 1 cycle with FIFO full) -> all outputs at reset values next cycle. Spurious grant with cdb_req=0 leaves count at 0.
- ALU_EXEC_STATS_EN build: 5 issues, flush with 3 in flight, 2 stall cycles -> stat_issued=5, stat_flushed=3, stat_stall=2.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: issue-side wrapper around the single-cycle ALU. It latches one op per cycle,
//   evaluates it through alu_simple, queues tagged results and hands them to the CDB.
// Latency: op accepted in cycle N -> cdb_req at N+2 at the earliest; sustains 1 op/cycle when
//   granted every cycle.
// Backpressure: a full result FIFO blocks Stage A, and a blocked Stage A drops issue_ready.
//   flush empties everything on the next cycle.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   issue_valid / issue_ready   handshake with the reservation station
//   issue_op/op1/op2/robid      op payload (alu_simple opcode, operands, ROB tag)
//   flush                       discard Stage A, the FIFO and any same-cycle accept
//   cdb_req / cdb_grant         head result request and arbiter grant
//   cdb_robid / cdb_result      head entry of the result FIFO
//   stat_issued/flushed/stall   event counters, present only when ALU_EXEC_STATS_EN is defined

// alu_simple: purely combinational ALU.
//   op[4]=0: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT, 9 SLTU.
//   op[4]=1 priority extensions over m = op1 & ~op2:
//     5'b10000 gives the index of the lowest set bit of m, or 32 when m is zero.
//     5'b10001 gives op1 with that lowest set bit of m cleared.
//   Every other opcode returns 0.
module alu_simple (
    input  logic [4:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result
);
    logic [31:0] masked;
    logic [31:0] lowbit;
    logic [5:0]  lowidx;

    assign masked = op1 & ~op2;
    // Two's-complement trick: isolates the lowest set bit of masked.
    assign lowbit = masked & (~masked + 32'd1);

    // Scan from the top down, so the last hit is the lowest set bit.
    always_comb begin
        lowidx = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (masked[i]) lowidx = 6'(i);
        end
    end

    always_comb begin
        result = 32'd0;
        case (op)
            5'b00000: result = op1 + op2;
            5'b00001: result = op1 - op2;
            5'b00010: result = op1 << op2[4:0];
            5'b00011: result = op1 >> op2[4:0];
            5'b00100: result = $unsigned($signed(op1) >>> op2[4:0]);
            5'b00101: result = op1 & op2;
            5'b00110: result = op1 | op2;
            5'b00111: result = op1 ^ op2;
            5'b01000: result = {31'd0, $signed(op1) < $signed(op2)};
            5'b01001: result = {31'd0, op1 < op2};
            5'b10000: result = {26'd0, lowidx};
            5'b10001: result = op1 & ~lowbit;
            default:  result = 32'd0;
        endcase
    end
endmodule

module alu_exec_stage #(
    parameter int DEPTH = 2,
    parameter int ROB_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_op,
    input  logic [31:0]      issue_op1,
    input  logic [31:0]      issue_op2,
    input  logic [ROB_W-1:0] issue_robid,
    input  logic             flush,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [ROB_W-1:0] cdb_robid,
    output logic [31:0]      cdb_result
`ifdef ALU_EXEC_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_flushed,
    output logic [31:0]      stat_stall
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Stage A operand latch
    logic             a_valid;
    logic [4:0]       a_op;
    logic [31:0]      a_op1;
    logic [31:0]      a_op2;
    logic [ROB_W-1:0] a_robid;

    // Result FIFO
    logic [ROB_W-1:0] fifo_robid  [DEPTH];
    logic [31:0]      fifo_result [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic        space;
    logic        a_adv;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] sc_result;

    // space looks only at the registered count: a pop this cycle does not free a slot
    // until the next one, which keeps issue_ready off the grant path.
    assign space       = (count < CNT_W'(DEPTH));
    assign a_adv       = a_valid & space;
    assign issue_ready = ~a_valid | a_adv;
    assign accept      = issue_valid & issue_ready;
    assign push        = a_adv & ~flush;
    assign pop         = cdb_req & cdb_grant;

    assign cdb_req    = (count != '0);
    assign cdb_robid  = fifo_robid[head];
    assign cdb_result = fifo_result[head];

    alu_simple u_alu (
        .op     (a_op),
        .op1    (a_op1),
        .op2    (a_op2),
        .result (sc_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_op    <= '0;
            a_op1   <= '0;
            a_op2   <= '0;
            a_robid <= '0;
        end else if (flush) begin
            a_valid <= 1'b0;
        end else if (accept) begin
            a_valid <= 1'b1;
            a_op    <= issue_op;
            a_op1   <= issue_op1;
            a_op2   <= issue_op2;
            a_robid <= issue_robid;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
        // Otherwise Stage A is idle or blocked and holds its contents.
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_robid[i]  <= '0;
                fifo_result[i] <= '0;
            end
        end else if (flush) begin
            // The storage is left stale on purpose; cdb_req masks it.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo_robid[tail]  <= a_robid;
                fifo_result[tail] <= sc_result;
                tail              <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Push is gated by space, so the FIFO can never overflow.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && count == CNT_W'(DEPTH)));
        end
    end

`ifdef ALU_EXEC_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_flushed <= '0;
            stat_stall   <= '0;
        end else begin
            stat_issued <= stat_issued + 32'(accept);
            stat_stall  <= stat_stall + 32'(issue_valid & ~issue_ready);
            // A pop in the flush cycle still reaches the CDB, so it is not counted as lost.
            if (flush) begin
                stat_flushed <= stat_flushed + 32'(a_valid) + 32'(count)
                                + 32'(accept) - 32'(pop);
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
    localparam int DEPTH = 2;
    localparam int ROB_W = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [4:0]       issue_op;
    logic [31:0]      issue_op1;
    logic [31:0]      issue_op2;
    logic [ROB_W-1:0] issue_robid;
    logic             flush;
    logic             cdb_req;
    logic             cdb_grant;
    logic [ROB_W-1:0] cdb_robid;
    logic [31:0]      cdb_result;
`ifdef ALU_EXEC_STATS_EN
    logic [31:0]      stat_issued;
    logic [31:0]      stat_flushed;
    logic [31:0]      stat_stall;
`endif

    alu_exec_stage #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_op1   (issue_op1),
        .issue_op2   (issue_op2),
        .issue_robid (issue_robid),
        .flush       (flush),
        .cdb_req     (cdb_req),
        .cdb_grant   (cdb_grant),
        .cdb_robid   (cdb_robid),
        .cdb_result  (cdb_result)
`ifdef ALU_EXEC_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_flushed(stat_flushed),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROB_W-1:0] robid;
        logic [31:0]      result;
    } res_t;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one optional op slot plus an in-order queue of finished results.
    bit          m_av;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [6:0]  m_rid;
    res_t        fq[$];
    res_t        obs_log[$];   // what the DUT actually delivered on granted cycles
    logic [31:0] s_iss, s_fl, s_st;

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit found;
        r = 0;
        found = 0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a << b[4:0];
            3:  r = a >> b[4:0];
            4:  r = $unsigned($signed(a) >>> b[4:0]);
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            9:  r = (a < b) ? 1 : 0;
            16: begin
                r = 32;
                for (int i = 0; i < 32; i++)
                    if (!found && a[i] && !b[i]) begin r = i; found = 1; end
            end
            17: begin
                r = a;
                for (int i = 0; i < 32; i++)
                    if (!found && a[i] && !b[i]) begin r[i] = 1'b0; found = 1; end
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic bit m_ready();
        return !m_av || fq.size() < DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic iv, input logic [4:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [6:0] rid, input logic fl, input logic gr);
        int sz;
        bit rdy, acc, pop, adv;
        sz = fq.size();
        if (!rst) begin
            fq.delete();
            m_av = 0; s_iss = 0; s_fl = 0; s_st = 0;
            return;
        end
        rdy = !m_av || sz < DEPTH;
        acc = iv && rdy;
        pop = (sz != 0) && gr;
        adv = m_av && sz < DEPTH;
        s_iss += 32'(acc);
        s_st  += 32'(iv && !rdy);
        if (fl) s_fl += 32'(m_av) + 32'(sz) + 32'(acc) - 32'(pop);
        if (fl) begin
            fq.delete();
            m_av = 0;
        end else begin
            if (pop) void'(fq.pop_front());
            if (adv) fq.push_back('{m_rid, ref_alu(m_op, m_a, m_b)});
            if (acc) begin
                m_av = 1; m_op = op; m_a = a; m_b = b; m_rid = rid;
            end else if (adv) begin
                m_av = 0;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, update the model at the rising edge.
    task automatic step(input bit chk_on, input logic rst, input logic iv, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [6:0] rid,
                        input logic fl, input logic gr);
        rst_n = rst; issue_valid = iv; issue_op = op; issue_op1 = a; issue_op2 = b;
        issue_robid = rid; flush = fl; cdb_grant = gr;
        #1;
        if (chk_on) begin
            chk("issue_ready", 32'(issue_ready), 32'(m_ready()));
            chk("cdb_req", 32'(cdb_req), 32'(fq.size() != 0));
            if (fq.size() != 0) begin
                chk("cdb_robid", 32'(cdb_robid), 32'(fq[0].robid));
                chk("cdb_result", cdb_result, fq[0].result);
            end
        end
        if (rst && cdb_req && gr) obs_log.push_back('{cdb_robid, cdb_result});
        @(posedge clk);
        model_edge(rst, iv, op, a, b, rid, fl, gr);
        @(negedge clk);
    endtask

    task automatic idle(input logic gr);
        step(1, 1, 0, 0, 0, 0, 0, 0, gr);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] rid, input logic gr);
        for (int i = 0; i < 20; i++) begin
            bit acc;
            acc = m_ready();
            step(1, 1, 1, op, a, b, rid, 0, gr);
            if (acc) return;
        end
        miscompares++;
        $error("FAIL issue_timeout robid=%0d observed=not_accepted expected=accepted", rid);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (fq.size() == 0 && !m_av) return;
            idle(1);
        end
        miscompares++;
        $error("FAIL drain_timeout observed=%0d_left expected=0_left", fq.size());
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [6:0] rid, input logic [31:0] res);
        if (obs_log.size() <= idx) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=missing expected=robid %0d", tag, rid);
        end else begin
            chk({tag, "_robid"}, 32'(obs_log[idx].robid), 32'(rid));
            chk({tag, "_result"}, obs_log[idx].result, res);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(cdb_req), 0);
        chk({tag, "_robid"}, 32'(cdb_robid), 0);
        chk({tag, "_result"}, cdb_result, 0);
        chk({tag, "_ready"}, 32'(issue_ready), 1);
    endtask

    initial begin
        rst_n = 0; issue_valid = 0; issue_op = 0; issue_op1 = 0; issue_op2 = 0;
        issue_robid = 0; flush = 0; cdb_grant = 0;
        m_av = 0; m_op = 0; m_a = 0; m_b = 0; m_rid = 0;
        s_iss = 0; s_fl = 0; s_st = 0;
        @(negedge clk);
        do_reset(2);
        #1 chk_reset_outputs("reset");

        // Single op with grant held high: visible at cycle 3, gone at cycle 4.
        obs_log.delete();
        issue(5'b00000, 7, 5, 3, 1);
        idle(1);
        #1;
        chk("single_req", 32'(cdb_req), 1);
        chk("single_robid", 32'(cdb_robid), 3);
        chk("single_result", cdb_result, 12);
        idle(1);
        #1 chk("single_req_gone", 32'(cdb_req), 0);

        // Back-to-back with no grant: FIFO fills, Stage A holds, issue_ready drops.
        obs_log.delete();
        issue(5'b00001, 10, 3, 1, 0);
        issue(5'b00010, 1, 4, 2, 0);
        issue(5'b00111, 32'hF0, 32'hFF, 3, 0);
        #1;
        chk("b2b_ready_low", 32'(issue_ready), 0);
        chk("b2b_head_robid", 32'(cdb_robid), 1);
        chk("b2b_head_result", cdb_result, 7);
        issue(5'b00110, 1, 2, 4, 1);
        drain();
        chk_log("b2b0", 0, 1, 7);
        chk_log("b2b1", 1, 2, 16);
        chk_log("b2b2", 2, 3, 32'h0F);
        chk_log("b2b3", 3, 4, 3);

        // Priority extensions.
        obs_log.delete();
        issue(5'b10000, 32'h0F00, 32'h0100, 5, 1);
        issue(5'b10001, 32'h0F00, 32'h0100, 6, 1);
        drain();
        chk_log("prio_idx", 0, 5, 32'h9);
        chk_log("prio_clr", 1, 6, 32'hD00);

        // Flush with two queued, Stage A valid and an op offered in the same cycle.
        issue(5'b00000, 100, 1, 10, 0);
        issue(5'b00000, 200, 2, 11, 0);
        issue(5'b00000, 300, 3, 12, 0);
        step(1, 1, 1, 5'b00000, 400, 4, 13, 1, 0);
        #1;
        chk("flush_req", 32'(cdb_req), 0);
        chk("flush_ready", 32'(issue_ready), 1);
        obs_log.delete();
        issue(5'b00000, 1, 1, 9, 1);
        idle(1);
        #1;
        chk("postflush_req", 32'(cdb_req), 1);
        chk("postflush_robid", 32'(cdb_robid), 9);
        chk("postflush_result", cdb_result, 2);
        drain();
        chk("postflush_count", obs_log.size(), 1);

        // Reset in the middle of a full pipeline, then a spurious grant.
        issue(5'b00000, 1, 2, 30, 0);
        issue(5'b00000, 3, 4, 31, 0);
        issue(5'b00000, 5, 6, 32, 0);
        do_reset(1);
        #1 chk_reset_outputs("midreset");
        idle(1);
        #1 chk("spurious_grant_req", 32'(cdb_req), 0);
        issue(5'b00000, 3, 4, 20, 0);
        idle(0);
        #1;
        chk("after_spurious_req", 32'(cdb_req), 1);
        chk("after_spurious_robid", 32'(cdb_robid), 20);
        chk("after_spurious_result", cdb_result, 7);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  rop;
            logic [31:0] ra, rb;
            rop = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(16, 17));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            step(1, 1, 1'($urandom_range(0, 3) != 0), rop, ra, rb, 7'($urandom_range(0, 127)),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0));
        end
        drain();

`ifdef ALU_EXEC_STATS_EN
        #1;
        chk("stat_issued", stat_issued, s_iss);
        chk("stat_flushed", stat_flushed, s_fl);
        chk("stat_stall", stat_stall, s_st);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
